// File: rtl/wb_wait_slave.sv
// Wishbone classic slave with a small byte-lane RAM window and a fixed,
// parameterised number of wait states before each single-cycle response.
module wb_wait_slave #(
   parameter int          DEPTH_LOG2  = 4,
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int AW    = DEPTH_LOG2;
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [3:0] WS_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state;
   state_t state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;

   logic          we_q;
   logic [3:0]    sel_q;
   logic [31:0]   dat_q;
   logic [AW-1:0] idx_q;
   logic          hit_q;

   logic          req;
   logic          hit_in;
   logic [AW-1:0] idx_in;
   logic          cap;
   logic          go;

   logic          live;
   logic          act_we;
   logic [3:0]    act_sel;
   logic [31:0]   act_dat;
   logic [AW-1:0] act_idx;
   logic          act_hit;
   logic [31:0]   cur_word;
   logic [31:0]   new_word;

   logic [31:0] mem [DEPTH];

   logic unused_adr;

   assign req    = wb_cyc_i & wb_stb_i;
   assign hit_in = wb_adr_i[31:AW+2] == BASE_ADR[31:AW+2];
   assign idx_in = wb_adr_i[AW+1:2];
   assign unused_adr = ^wb_adr_i[1:0];

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // A dropped cycle in WAIT wins over the final countdown edge.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap      = 1'b0;
      go       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               cap = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nx = S_RESP;
                  go       = 1'b1;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = WS_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               state_nx = S_IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nx = S_RESP;
               go       = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_RESP: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   // Zero-wait responses act on the live bus; otherwise on the captured copy.
   always_comb begin
      live    = (state == S_IDLE);
      act_we  = live ? wb_we_i  : we_q;
      act_sel = live ? wb_sel_i : sel_q;
      act_dat = live ? wb_dat_i : dat_q;
      act_idx = live ? idx_in   : idx_q;
      act_hit = live ? hit_in   : hit_q;
   end

   assign cur_word = mem[act_idx];

   always_comb begin
      new_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (act_sel[b]) begin
            new_word[8*b +: 8] = act_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         we_q  <= 1'b0;
         sel_q <= 4'd0;
         dat_q <= 32'd0;
         idx_q <= '0;
         hit_q <= 1'b0;
      end else if (cap) begin
         we_q  <= wb_we_i;
         sel_q <= wb_sel_i;
         dat_q <= wb_dat_i;
         idx_q <= idx_in;
         hit_q <= hit_in;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (go && act_hit && act_we) begin
         mem[act_idx] <= new_word;
      end
   end

   // Write responses return the merged word so the bus sees the stored value.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= 32'd0;
      end else begin
         wb_ack_o <= go & act_hit;
         wb_err_o <= go & ~act_hit;
         if (go) begin
            if (!act_hit) begin
               wb_dat_o <= 32'd0;
            end else if (act_we) begin
               wb_dat_o <= new_word;
            end else begin
               wb_dat_o <= cur_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_wait_slave.sv
// Bench for wb_wait_slave: a zero-wait default instance and a three-wait
// instance with a non-zero reset value, checked against a word-array model.
module tb_wb_wait_slave;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] RV1  = 32'h5A5A_5A5A;

   logic        clk;
   logic        rst_n [2];
   logic        cyc   [2];
   logic        stb   [2];
   logic        we    [2];
   logic [3:0]  sel   [2];
   logic [31:0] adr   [2];
   logic [31:0] wdat  [2];
   logic [31:0] rdat  [2];
   logic        ack   [2];
   logic        err   [2];

   logic [31:0] mm [2][16];

   int checks = 0;
   int errors = 0;

   wb_wait_slave u0 (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n[0]),
      .wb_stb_i  (stb[0]),
      .wb_cyc_i  (cyc[0]),
      .wb_we_i   (we[0]),
      .wb_sel_i  (sel[0]),
      .wb_adr_i  (adr[0]),
      .wb_dat_i  (wdat[0]),
      .wb_dat_o  (rdat[0]),
      .wb_ack_o  (ack[0]),
      .wb_err_o  (err[0])
   );

   wb_wait_slave #(
      .WAIT_STATES (3),
      .RESET_VAL   (RV1)
   ) u1 (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n[1]),
      .wb_stb_i  (stb[1]),
      .wb_cyc_i  (cyc[1]),
      .wb_we_i   (we[1]),
      .wb_sel_i  (sel[1]),
      .wb_adr_i  (adr[1]),
      .wb_dat_i  (wdat[1]),
      .wb_dat_o  (rdat[1]),
      .wb_ack_o  (ack[1]),
      .wb_err_o  (err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int wsof(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] v,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = v[8*b +: 8];
      return r;
   endfunction

   function automatic void model_reset(input int d);
      for (int i = 0; i < 16; i++)
         mm[d][i] = (d == 0) ? 32'd0 : RV1;
   endfunction

   task automatic xfer(input int d, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] v,
                       input string tag);
      logic hit;
      int idx;
      int n;
      logic [31:0] expd;
      hit = (a / 64) == (BASE / 64);
      idx = int'((a / 4) % 16);
      if (hit && w) mm[d][idx] = merge(mm[d][idx], v, s);
      expd = hit ? mm[d][idx] : 32'd0;
      we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = v;
      cyc[d] = 1'b1; stb[d] = 1'b1;
      @(posedge clk); #1;
      stb[d] = 1'b0;
      we[d] = 1'($urandom);
      sel[d] = 4'($urandom);
      adr[d] = $urandom;
      wdat[d] = $urandom;
      n = 0;
      while (!(ack[d] | err[d]) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".lat"}, 32'(n), 32'(wsof(d)));
      chk({tag, ".ack"}, {31'd0, ack[d]}, {31'd0, hit});
      chk({tag, ".err"}, {31'd0, err[d]}, {31'd0, !hit});
      chk({tag, ".dat"}, rdat[d], expd);
      @(posedge clk); #1;
      cyc[d] = 1'b0;
      chk({tag, ".pulse"}, {30'd0, ack[d], err[d]}, 32'd0);
      chk({tag, ".hold"}, rdat[d], expd);
   endtask

   task automatic quiet(input int d, input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         chk(tag, {30'd0, ack[d], err[d]}, 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic abort1(input logic w, input logic [31:0] a,
                         input logic [31:0] v);
      we[1] = w; sel[1] = 4'hF; adr[1] = a; wdat[1] = v;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      stb[1] = 1'b0;
      @(posedge clk); #1;
      cyc[1] = 1'b0;
      quiet(1, 6, "abort.quiet");
   endtask

   task automatic rand_xfer(input int d, input string tag);
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = BASE + 32'($urandom_range(64, 127));
      else a = BASE + 32'($urandom_range(0, 63));
      xfer(d, 1'($urandom), 4'($urandom), a, $urandom, tag);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
         sel[d] = 4'd0; adr[d] = 32'd0; wdat[d] = 32'd0;
         model_reset(d);
      end
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst.ack", {31'd0, ack[d]}, 32'd0);
         chk("rst.err", {31'd0, err[d]}, 32'd0);
         chk("rst.dat", rdat[d], 32'd0);
      end
      #20;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(posedge clk); #1;

      xfer(0, 1'b1, 4'hF, 32'h3000_0008, 32'hDEAD_BEEF, "d0.wr8");
      xfer(0, 1'b0, 4'hF, 32'h3000_0008, 32'd0, "d0.rd8");
      chk("d0.deadbeef", rdat[0], 32'hDEAD_BEEF);

      xfer(0, 1'b1, 4'hF, 32'h3000_000C, 32'h1122_3344, "d0.wrC");
      xfer(0, 1'b1, 4'b0101, 32'h3000_000C, 32'hAABB_CCDD, "d0.lane");
      xfer(0, 1'b0, 4'hF, 32'h3000_000C, 32'd0, "d0.rdC");
      chk("d0.lanes", rdat[0], 32'h11BB_33DD);
      xfer(0, 1'b1, 4'h0, 32'h3000_000C, 32'hFFFF_FFFF, "d0.sel0");
      xfer(0, 1'b0, 4'hF, 32'h3000_000C, 32'd0, "d0.rdC2");
      chk("d0.sel0keep", rdat[0], 32'h11BB_33DD);

      xfer(0, 1'b1, 4'hF, 32'h3000_0040, 32'h1234_5678, "d0.misswr");
      xfer(0, 1'b0, 4'hF, 32'h3000_0000, 32'd0, "d0.rd0");
      xfer(0, 1'b0, 4'hF, 32'h3000_0008, 32'd0, "d0.rd8b");
      xfer(0, 1'b0, 4'hF, 32'h3000_0040, 32'd0, "d0.missrd");
      chk("d0.missdat", rdat[0], 32'd0);

      xfer(0, 1'b1, 4'hF, 32'h3000_003C, 32'h0F0F_0F0F, "d0.wr3C");
      xfer(0, 1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678, "d0.wr00");
      xfer(0, 1'b0, 4'hF, 32'h3000_003C, 32'd0, "d0.rd3C");
      chk("d0.wrap15", rdat[0], 32'h0F0F_0F0F);
      xfer(0, 1'b0, 4'hF, 32'h3000_0000, 32'd0, "d0.rd00");
      chk("d0.wrap0", rdat[0], 32'h1234_5678);
      xfer(0, 1'b0, 4'hF, 32'h3000_003E, 32'd0, "d0.alias");
      chk("d0.alias15", rdat[0], 32'h0F0F_0F0F);

      we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h3000_0008;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("d0.b2b", {31'd0, ack[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i < 3) @(posedge clk);
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) rand_xfer(0, "d0.rand");

      xfer(1, 1'b0, 4'hF, 32'h3000_0000, 32'd0, "d1.rd0");
      chk("d1.rstval", rdat[1], RV1);
      abort1(1'b0, 32'h3000_0010, 32'd0);
      xfer(1, 1'b0, 4'hF, 32'h3000_0014, 32'd0, "d1.afterab");
      abort1(1'b1, 32'h3000_0004, 32'h0000_0000);
      xfer(1, 1'b0, 4'hF, 32'h3000_0004, 32'd0, "d1.noabwr");
      chk("d1.abkeep", rdat[1], RV1);
      xfer(1, 1'b1, 4'b1100, 32'h3000_0018, 32'h1357_9BDF, "d1.lane");
      xfer(1, 1'b1, 4'hF, 32'h3000_0080, 32'h1, "d1.miss");

      for (int i = 0; i < 30; i++) rand_xfer(1, "d1.rand");

      xfer(1, 1'b1, 4'hF, 32'h3000_0008, 32'hCAFE_F00D, "d1.wr8");
      xfer(1, 1'b0, 4'hF, 32'h3000_0008, 32'd0, "d1.rd8");
      we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h3000_0008;
      wdat[1] = 32'h0; cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      stb[1] = 1'b0;
      @(posedge clk); #3;
      rst_n[1] = 1'b0;
      cyc[1] = 1'b0;
      #1;
      chk("d1.arst.ack", {31'd0, ack[1]}, 32'd0);
      chk("d1.arst.err", {31'd0, err[1]}, 32'd0);
      chk("d1.arst.dat", rdat[1], 32'd0);
      model_reset(1);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n[1] = 1'b1;
      @(posedge clk); #1;
      quiet(1, 8, "d1.postrst");
      for (int i = 0; i < 16; i++)
         xfer(1, 1'b0, 4'hF, BASE + 32'(4 * i), 32'd0, "d1.rstrd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
